// File: rtl/fetch_pkg.sv
// Shared constants and the queue entry type for the instruction fetch queue.
package fetch_pkg;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Two-entry circular buffer of fetched {pc, inst}; push/pop/flush, head visible combinationally.
// Flush dominates push and pop; push with pop on a full buffer keeps the count at 2.
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_push_dat,
    output fetch_entry_t o_head_dat,
    output logic [1:0]   o_count
);
    fetch_entry_t r_mem [2];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else if (i_flush) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (i_push) r_wptr <= ~r_wptr;
            if (i_pop)  r_rptr <= ~r_rptr;
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    // Storage needs no reset: an entry is only read while the count covers it.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) r_mem[r_wptr] <= i_push_dat;
    end

    assign o_head_dat = r_mem[r_rptr];
    assign o_count    = r_count;
endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch PC, credit and redirect control feeding a 2-entry queue toward decode.
// Request-to-visible latency 2 cycles; a redirect takes 3 cycles to show its target.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        stall,
    input  logic        PCSrc,
    input  logic [31:0] PCimm_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        valid_out,
    output logic [31:0] r_PC_out,
    output logic [31:0] r_inst_out
);
    localparam logic [2:0] CREDIT_LIMIT = 3'(DEPTH);

    logic [31:0]  r_pc;
    logic         r_in_flight;
    logic [31:0]  r_req_pc;

    logic         w_deq;
    logic         w_push;
    logic         w_credit;
    logic [2:0]   w_occupancy;
    logic [1:0]   w_count;
    logic [1:0]   w_unused_lsb;
    fetch_entry_t w_head;
    fetch_entry_t w_push_dat;

    assign w_unused_lsb = PCimm_in[1:0];

    assign valid_out   = (w_count != 2'd0);
    assign w_deq       = valid_out && !stall && !PCSrc;
    assign w_occupancy = {1'b0, w_count} + {2'b00, r_in_flight} - {2'b00, w_deq};
    assign w_credit    = (w_occupancy < CREDIT_LIMIT);
    assign imem_req    = !RESET && !PCSrc && w_credit;
    assign imem_addr   = r_pc;

    // The only response that can be in flight during a redirect arrives in that
    // same cycle, so killing it reduces to gating the push with PCSrc.
    assign w_push          = r_in_flight && !PCSrc;
    assign w_push_dat.pc   = r_req_pc;
    assign w_push_dat.inst = imem_rdata;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pc        <= RESET_PC;
            r_in_flight <= 1'b0;
            r_req_pc    <= 32'd0;
        end else if (PCSrc) begin
            r_pc        <= {PCimm_in[31:2], 2'b00};
            r_in_flight <= 1'b0;
        end else begin
            r_in_flight <= imem_req;
            if (imem_req) begin
                r_req_pc <= r_pc;
                r_pc     <= r_pc + PC_STEP;
            end
        end
    end

    fetch_fifo u_fifo (
        .i_clk      (CLK),
        .i_rst      (RESET),
        .i_push     (w_push),
        .i_pop      (w_deq),
        .i_flush    (PCSrc),
        .i_push_dat (w_push_dat),
        .o_head_dat (w_head),
        .o_count    (w_count)
    );

    assign r_PC_out   = valid_out ? w_head.pc   : 32'd0;
    assign r_inst_out = valid_out ? w_head.inst : NOP_INST;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomised and directed bench for instr_fetch_queue against a queue-level model.
module tb_instr_fetch_queue;
    import fetch_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        stall = 1'b0;
    logic        PCSrc = 1'b0;
    logic [31:0] PCimm_in = 32'd0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] imem_rdata_w = 32'd0;
    logic        imem_req, valid_out, imem_req_w, valid_out_w;
    logic [31:0] imem_addr, r_PC_out, r_inst_out;
    logic [31:0] imem_addr_w, r_PC_out_w, r_inst_out_w;

    always #5 CLK = ~CLK;

    instr_fetch_queue dut (
        .CLK(CLK), .RESET(RESET), .stall(stall), .PCSrc(PCSrc), .PCimm_in(PCimm_in),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .valid_out(valid_out), .r_PC_out(r_PC_out), .r_inst_out(r_inst_out)
    );

    instr_fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .CLK(CLK), .RESET(RESET), .stall(1'b0), .PCSrc(1'b0), .PCimm_in(32'd0),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
        .valid_out(valid_out_w), .r_PC_out(r_PC_out_w), .r_inst_out(r_inst_out_w)
    );

    int n_chk = 0;
    int n_fail = 0;

    fetch_entry_t mq[$];
    logic [31:0]  m_pc;
    bit           m_if;
    logic [31:0]  m_if_pc;
    bit           last_req, last_req_w;
    logic [31:0]  last_addr, last_addr_w;
    logic         c_valid, c_req;
    logic [31:0]  c_pc, c_inst, c_addr, c_pc_w;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, ~a[31:16]};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset(input logic [31:0] rpc);
        mq.delete();
        m_pc = rpc;
        m_if = 1'b0;
        last_req = 1'b0;
        last_req_w = 1'b0;
    endtask

    // One cycle: entered and left at posedge+1.
    task automatic step(input logic s, input logic p, input logic [31:0] t);
        bit          exp_valid, deq, exp_req;
        int          occ;
        logic [31:0] exp_pc, exp_inst;
        stall = s;
        PCSrc = p;
        PCimm_in = t;
        imem_rdata   = last_req   ? memf(last_addr)   : $urandom;
        imem_rdata_w = last_req_w ? memf(last_addr_w) : 32'd0;
        #3;
        exp_valid = (mq.size() != 0);
        exp_pc    = exp_valid ? mq[0].pc   : 32'd0;
        exp_inst  = exp_valid ? mq[0].inst : NOP_INST;
        deq       = exp_valid && !s && !p;
        occ       = mq.size() + int'(m_if) - int'(deq);
        exp_req   = !p && (occ < 2);
        chk("valid_out", {31'd0, valid_out}, {31'd0, exp_valid});
        chk("r_PC_out", r_PC_out, exp_pc);
        chk("r_inst_out", r_inst_out, exp_inst);
        chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, m_pc);
        c_valid = valid_out; c_pc = r_PC_out; c_inst = r_inst_out;
        c_req = imem_req; c_addr = imem_addr; c_pc_w = r_PC_out_w;
        if (p) begin
            mq.delete();
            m_if = 1'b0;
            m_pc = {t[31:2], 2'b00};
        end else begin
            if (deq) void'(mq.pop_front());
            if (m_if) mq.push_back('{pc: m_if_pc, inst: imem_rdata});
            m_if = exp_req;
            m_if_pc = m_pc;
            if (exp_req) m_pc = m_pc + 32'd4;
        end
        last_req = imem_req;     last_addr = imem_addr;
        last_req_w = imem_req_w; last_addr_w = imem_addr_w;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc", r_PC_out, 32'd0);
        chk("rst_inst", r_inst_out, 32'h0000_0013);
        @(posedge CLK); @(posedge CLK); #1;
        RESET = 1'b0;
        model_reset(32'd0);

        // Straight-line fetch from reset, wrap instance alongside.
        step(0, 0, 0);
        chk("c0_req", {31'd0, c_req}, 32'd1);
        chk("c0_addr", c_addr, 32'd0);
        chk("c0_valid", {31'd0, c_valid}, 32'd0);
        step(0, 0, 0);
        chk("c1_valid", {31'd0, c_valid}, 32'd0);
        step(0, 0, 0);
        chk("c2_pc", c_pc, 32'd0);
        chk("c2_inst", c_inst, memf(32'd0));
        chk("wrap_c2", c_pc_w, 32'hFFFF_FFF8);
        step(0, 0, 0);
        chk("c3_pc", c_pc, 32'd4);
        chk("wrap_c3", c_pc_w, 32'hFFFF_FFFC);

        // Stall five cycles with PC 8 at the head.
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0);
            chk("stall_pc", c_pc, 32'd8);
            chk("stall_req", {31'd0, c_req}, 32'd0);
            if (i == 0) chk("wrap_c4", c_pc_w, 32'h0000_0000);
        end
        step(0, 0, 0);
        chk("rel_pc", c_pc, 32'd8);
        chk("rel_addr", c_addr, 32'd16);
        step(0, 0, 0);
        chk("rel_pc12", c_pc, 32'd12);
        step(0, 0, 0);
        chk("rel_pc16", c_pc, 32'd16);

        // Redirect with a fetch in flight.
        step(0, 1, 32'h0000_0100);
        chk("redir_req", {31'd0, c_req}, 32'd0);
        step(0, 0, 0);
        chk("redir_v1", {31'd0, c_valid}, 32'd0);
        chk("redir_addr", c_addr, 32'h0000_0100);
        step(0, 0, 0);
        chk("redir_v2", {31'd0, c_valid}, 32'd0);
        step(0, 0, 0);
        chk("redir_pc", c_pc, 32'h0000_0100);
        chk("redir_inst", c_inst, memf(32'h0000_0100));

        // Redirect while stalled, unaligned target.
        step(1, 1, 32'h0000_0203);
        step(0, 0, 0);
        chk("stredir_addr", c_addr, 32'h0000_0200);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("stredir_pc", c_pc, 32'h0000_0200);

        // Back-to-back redirects: last one wins.
        step(0, 1, 32'h0000_0300);
        step(0, 1, 32'h0000_0400);
        step(0, 0, 0);
        chk("b2b_addr", c_addr, 32'h0000_0400);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("b2b_pc", c_pc, 32'h0000_0400);

        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0, $urandom);

        // Fill the queue, then reset mid-cycle.
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        chk("full_valid", {31'd0, c_valid}, 32'd1);
        RESET = 1'b1;
        #1;
        chk("arst_valid", {31'd0, valid_out}, 32'd0);
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        chk("arst_pc", r_PC_out, 32'd0);
        chk("arst_inst", r_inst_out, 32'h0000_0013);
        @(posedge CLK); #1;
        RESET = 1'b0;
        model_reset(32'd0);
        step(0, 0, 0);
        chk("post_rst_addr", c_addr, 32'd0);
        chk("post_rst_req", {31'd0, c_req}, 32'd1);
        for (int i = 0; i < 6; i++) step(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter DEPTH, default 2, queue entries; only value 2 SHALL be supported.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  consumer (decode) hold; 1 = do not dequeue.
REQ-006 PCSrc  input  1  redirect request from branch/jump resolution.
REQ-007 PCimm_in  input  32  redirect target PC.
REQ-008 imem_req  output  1  instruction memory read request.
REQ-009 imem_addr  output  32  word-aligned fetch address.
REQ-010 imem_rdata  input  32  instruction word, valid exactly one cycle after imem_req.
REQ-011 valid_out  output  1  head entry valid.
REQ-012 r_PC_out  output  32  PC of head entry.
REQ-013 r_inst_out  output  32  instruction of head entry; 32'h0000_0013 (NOP) when valid_out=0.

Function
REQ-014 Fetch PC register SHALL issue imem_req with imem_addr=PC when credit available and PCSrc=0, then PC <= PC+4.
REQ-015 Credit SHALL be available when (entries + in_flight - dequeue_this_cycle) < 2.
REQ-016 PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-017 Response in cycle N+1 for request in cycle N SHALL be pushed with its PC at end of N+1; valid_out rises in N+2 (latency 2).
REQ-018 Dequeue SHALL occur when valid_out=1 and stall=0; head advances next cycle.
REQ-019 Sustained throughput with stall=0 SHALL be one instruction per cycle.
REQ-020 stall=1 SHALL hold r_PC_out/r_inst_out/valid_out stable; fetching continues until queue full, then imem_req=0.
REQ-021 Simultaneous push and dequeue on a full queue SHALL be legal and keep count at 2; push on full without dequeue SHALL never occur.
REQ-022 PCSrc=1 SHALL: flush all entries (valid_out=0 next cycle), mark any in-flight response killed (not pushed), load PC <= {PCimm_in[31:2],2'b00}, and deassert imem_req that cycle.
REQ-023 Redirect SHALL take priority over stall, dequeue and push in the same cycle.
REQ-024 Target instruction SHALL appear on valid_out three cycles after the PCSrc cycle (issue +1, response +2, visible +3).
REQ-025 Back-to-back PCSrc cycles SHALL each apply; the last target wins.
REQ-026 Queue SHALL be a circular buffer with 1-bit read/write pointers and 2-bit count.

Reset
REQ-027 RESET=1 SHALL asynchronously force PC=RESET_PC, count=0, pointers=0, in_flight=0, kill=0.
REQ-028 During reset outputs SHALL be imem_req=0, valid_out=0, r_PC_out=0, r_inst_out=NOP.
REQ-029 First imem_req SHALL occur in the first cycle after RESET deasserts; reset mid-operation SHALL discard all queued and in-flight state.

Structure
REQ-030 Package fetch_pkg SHALL hold NOP_INST (32'h0000_0013), PC_STEP (4) and the entry type {pc[31:0], inst[31:0]}.
REQ-031 Sub-module fetch_fifo (2-entry, push/pop/flush, count) SHALL hold the buffer; PC/credit/kill logic stays in instr_fetch_queue.

Verification
REQ-032 Reset release, stall=0, imem returns addr-based words -> imem_addr 0,4,8...; valid_out from cycle 2, r_PC_out 0,4,8 one per cycle.
REQ-033 stall=1 for 5 cycles from r_PC_out=8 -> outputs frozen at PC 8, imem_req drops after queue full, resumes PC 16 on release with no loss/duplication.
REQ-034 PCSrc=1, PCimm_in=32'h0000_0100 with in-flight fetch -> killed word never appears; valid_out=0 for 2 cycles; r_PC_out=0x100 on third cycle.
REQ-035 PCSrc=1 with PCimm_in=32'h0000_0203 while stall=1 -> flush wins, fetch resumes at 0x200.
REQ-036 RESET_PC=32'hFFFF_FFF8 -> r_PC_out sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 Assert RESET with queue full -> valid_out=0 immediately (asynchronous); after release fetch restarts at RESET_PC.
